// File: rtl/spi_config_regs_if.sv
// SPI slave pin bundle (sclk, copi, ncs) seen by the configuration front end.
// Latency: none, plain wires.
// Backpressure: none; the SPI master owns all three pins and copi is never driven back.
// Ports: master modport drives sclk/copi/ncs, slave modport samples them.
interface spi_config_regs_if;
    logic sclk;
    logic copi;
    logic ncs;

    modport master (
        output sclk,
        output copi,
        output ncs
    );

    modport slave (
        input sclk,
        input copi,
        input ncs
    );
endinterface

// File: rtl/spi_config_regs.sv
// SPI-slave write-only front end committing 16-bit frames into five 8-bit PWM config registers.
// Latency: a register updates SYNC_STAGES+1 clk edges after the ncs rising edge is first captured.
// Backpressure: none; frames are accepted at wire speed, and malformed, read or out-of-range frames are dropped.
// Ports: clk/rst_n (async active-low); spi = slave pins {sclk, copi, ncs};
//        en_reg_out_7_0 (0x00), en_reg_out_15_8 (0x01), en_reg_pwm_7_0 (0x02),
//        en_reg_pwm_15_8 (0x03), pwm_duty_cycle (0x04), all registered.
module spi_config_regs #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = 7'h04
) (
    input  logic                clk,
    input  logic                rst_n,
    spi_config_regs_if.slave    spi,
    output logic [7:0]          en_reg_out_7_0,
    output logic [7:0]          en_reg_out_15_8,
    output logic [7:0]          en_reg_pwm_7_0,
    output logic [7:0]          en_reg_pwm_15_8,
    output logic [7:0]          pwm_duty_cycle
);

    localparam logic [4:0] CNT_FULL = 5'd16;
    // One past a full frame: sticks here so an overlong frame stays rejectable.
    localparam logic [4:0] CNT_SAT  = 5'd17;

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers and edge-detect history
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] copi_sync_q;
    logic [SYNC_STAGES-1:0] ncs_sync_q;
    logic                   sclk_hist_q;
    logic                   ncs_hist_q;

    logic sclk_s;
    logic copi_s;
    logic ncs_s;
    logic sclk_rise;
    logic ncs_rise;

    // The ncs chain resets to 0 (selected) so that a master still holding
    // ncs low across reset release is not mistaken for an idle bus; the FSM
    // then waits for a genuine high before accepting a new frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            ncs_sync_q  <= '0;
            sclk_hist_q <= 1'b0;
            ncs_hist_q  <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], spi.copi};
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], spi.ncs};
            sclk_hist_q <= sclk_s;
            ncs_hist_q  <= ncs_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign copi_s    = copi_sync_q[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_hist_q;
    assign ncs_rise  = ncs_s & ~ncs_hist_q;

    // ------------------------------------------------------------------
    // Frame FSM and datapath
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [15:0] shift_q, shift_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [7:0]  regs_q [5];
    logic [7:0]  regs_d [5];
    logic        wr_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < 5; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < 5; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            regs_d[i] = regs_q[i];
        end

        case (state_q)
            // Drop whatever frame was in flight when reset released.
            WAIT_IDLE: begin
                if (ncs_s) begin
                    state_d = IDLE;
                end
            end

            // IDLE is only reached with ncs high, except when a new frame
            // started during the COMMIT cycle; testing the level rather than
            // the one-cycle fall pulse catches that case too.
            IDLE: begin
                if (!ncs_s) begin
                    shift_d = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                // Gating with ncs_s keeps a late sclk edge that coincides
                // with deselection out of the frame.
                if (sclk_rise && !ncs_s) begin
                    shift_d = {shift_q[14:0], copi_s};
                    if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                if (ncs_rise) begin
                    state_d = COMMIT;
                end
            end

            COMMIT: begin
                wr_en   = (cnt_q == CNT_FULL) && shift_q[15] && (shift_q[14:8] <= MAX_ADDR);
                state_d = IDLE;
            end

            default: begin
                state_d = WAIT_IDLE;
            end
        endcase

        // Addresses accepted by MAX_ADDR but without a backing register are
        // ignored.
        if (wr_en) begin
            case (shift_q[14:8])
                7'h00:   regs_d[0] = shift_q[7:0];
                7'h01:   regs_d[1] = shift_q[7:0];
                7'h02:   regs_d[2] = shift_q[7:0];
                7'h03:   regs_d[3] = shift_q[7:0];
                7'h04:   regs_d[4] = shift_q[7:0];
                default: ;
            endcase
        end
    end

    assign en_reg_out_7_0  = regs_q[0];
    assign en_reg_out_15_8 = regs_q[1];
    assign en_reg_pwm_7_0  = regs_q[2];
    assign en_reg_pwm_15_8 = regs_q[3];
    assign pwm_duty_cycle  = regs_q[4];

endmodule
